// File: rtl/bsg_fifo_1r1w_small.sv
// Small 1-read/1-write FIFO with registered storage and extra-wrap-bit pointers.
// No bypass path: a beat written in one cycle is readable from the next cycle on.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 16,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_width_lp:0] r_wptr, r_rptr;
  logic w_empty, w_full, w_push, w_pop;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ptr_width_lp] != r_rptr[ptr_width_lp])
                && (r_wptr[ptr_width_lp-1:0] == r_rptr[ptr_width_lp-1:0]);

  // When full, a same-cycle pop frees the head slot, which is exactly the write slot.
  assign w_push = v_i & (~w_full | yumi_i);
  assign w_pop  = yumi_i & ~w_empty;

  assign ready_o = ~w_full;
  assign v_o     = ~w_empty;
  assign data_o  = r_mem[r_rptr[ptr_width_lp-1:0]];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && w_push) r_mem[r_wptr[ptr_width_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bsg_cache_to_dram_ctrl_rx.sv
// DRAM read-return stage: burst-granular request credits, beat buffering FIFO,
// and end-of-burst framing check with sticky overflow/framing error flags.
module bsg_cache_to_dram_ctrl_rx #(
  parameter int dma_data_width_p      = 16,
  parameter int dma_burst_len_p       = 4,
  parameter int dram_ctrl_burst_len_p = 4,
  parameter int fifo_els_p            = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        rd_req_v_i,
  output logic                        rd_req_ready_o,
  input  logic                        app_rd_data_valid_i,
  input  logic [dma_data_width_p-1:0] app_rd_data_i,
  input  logic                        app_rd_data_end_i,
  output logic [dma_data_width_p-1:0] dma_data_o,
  output logic                        dma_data_v_o,
  input  logic                        dma_data_ready_i,
  output logic                        overflow_o,
  output logic                        end_err_o
);

  localparam int lg_fifo_els_lp    = $clog2(fifo_els_p);
  localparam int credit_width_lp   = $clog2(fifo_els_p + 1);
  localparam int beat_cnt_width_lp = (dram_ctrl_burst_len_p > 1) ? $clog2(dram_ctrl_burst_len_p) : 1;

  logic [credit_width_lp-1:0]   r_credits;
  logic [beat_cnt_width_lp-1:0] r_beat_cnt;
  logic r_overflow, r_end_err;
  logic w_accept, w_pop, w_fifo_ready, w_last_beat;

  bsg_fifo_1r1w_small #(
    .width_p (dma_data_width_p),
    .els_p   (fifo_els_p)
  ) fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (app_rd_data_valid_i),
    .data_i  (app_rd_data_i),
    .ready_o (w_fifo_ready),
    .v_o     (dma_data_v_o),
    .data_o  (dma_data_o),
    .yumi_i  (w_pop)
  );

  assign rd_req_ready_o = (r_credits >= credit_width_lp'(dma_burst_len_p));
  assign w_accept       = rd_req_v_i & rd_req_ready_o;
  assign w_pop          = dma_data_v_o & dma_data_ready_i;
  assign w_last_beat    = (r_beat_cnt == beat_cnt_width_lp'(dram_ctrl_burst_len_p - 1));
  assign overflow_o     = r_overflow;
  assign end_err_o      = r_end_err;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_credits <= credit_width_lp'(fifo_els_p);
    end else begin
      r_credits <= r_credits
                 - (w_accept ? credit_width_lp'(dma_burst_len_p) : '0)
                 + (w_pop    ? credit_width_lp'(1)               : '0);
    end
  end

  // Beat counter advances on every controller beat, dropped or not, and never resyncs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_beat_cnt <= '0;
      r_overflow <= 1'b0;
      r_end_err  <= 1'b0;
    end else if (app_rd_data_valid_i) begin
      r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
      if (!w_fifo_ready && !w_pop)             r_overflow <= 1'b1;
      if (app_rd_data_end_i != w_last_beat)    r_end_err  <= 1'b1;
    end
  end

  logic unused_lg;
  assign unused_lg = ^lg_fifo_els_lp;

endmodule
